// File: rtl/smf_pkg.sv
// Shared definitions for the switching median filter threshold detector:
// pixel width, counter width default, default threshold and frame FSM states.
package smf_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W_DEF = 16;
  localparam logic [PIX_W-1:0] DEFAULT_THR = 8'd40;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/frame_noise_counter.sv
// Per-frame count of substituted pixels with framing supervision.
// Publishes the final count with a one-cycle strobe when a frame closes.
module frame_noise_counter
  import smf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             accept,
  input  logic             noisy,
  input  logic             frame_start,
  input  logic             frame_end,
  output logic [CNT_W-1:0] noise_count,
  output logic             count_valid,
  output logic             sync_error
);

  frame_state_t     state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] noise_count_reg;
  logic             count_valid_reg;
  logic             sync_error_reg;

  // Running count including the current beat, pinned at all-ones.
  always_comb begin
    cnt_next = cnt_reg;
    if (noisy && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      noise_count_reg <= '0;
      count_valid_reg <= 1'b0;
      sync_error_reg  <= 1'b0;
    end else begin
      count_valid_reg <= 1'b0;
      if (accept) begin
        if (frame_start) begin
          // A start inside an open frame aborts it without publishing.
          if (state_reg == ACTIVE) begin
            sync_error_reg <= 1'b1;
          end
          if (frame_end) begin
            noise_count_reg <= CNT_W'(noisy);
            count_valid_reg <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            cnt_reg   <= CNT_W'(noisy);
            state_reg <= ACTIVE;
          end
        end else if (state_reg == IDLE) begin
          sync_error_reg <= 1'b1;
        end else if (frame_end) begin
          noise_count_reg <= cnt_next;
          count_valid_reg <= 1'b1;
          state_reg       <= IDLE;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  end

  assign noise_count = noise_count_reg;
  assign count_valid = count_valid_reg;
  assign sync_error  = sync_error_reg;

endmodule

// File: rtl/switch_decision_stage.sv
// Noise decision and pixel substitution with a two-stage valid/ready pipeline.
// Thresholds switch only on an accepted frame-start beat.
module switch_decision_stage
  import smf_pkg::*;
#(
  parameter logic [PIX_W-1:0] DEFAULT_THRESHOLD = DEFAULT_THR,
  parameter int               CNT_W             = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [PIX_W-1:0] CV,
  input  logic [PIX_W-1:0] MV,
  input  logic [PIX_W-1:0] AD,
  input  logic             Frame_Start,
  input  logic             Frame_End,
  input  logic [PIX_W-1:0] Threshold,
  input  logic             Threshold_Load,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [PIX_W-1:0] Pixel_Out,
  output logic             Noise_Flag,
  output logic [CNT_W-1:0] Noise_Count,
  output logic             Count_Valid,
  output logic             Sync_Error
);

  logic [PIX_W-1:0] pending_thr_reg;
  logic [PIX_W-1:0] active_thr_reg;
  logic [PIX_W-1:0] beat_thr;
  logic             noisy;
  logic             accept;
  logic             adv2;

  logic             s1_valid_reg;
  logic [PIX_W-1:0] s1_pix_reg;
  logic             s1_flag_reg;
  logic             out_valid_reg;
  logic [PIX_W-1:0] out_pix_reg;
  logic             out_flag_reg;

  assign adv2     = ~out_valid_reg | Out_Ready;
  assign In_Ready = ~s1_valid_reg | adv2;
  assign accept   = In_Valid & In_Ready;

  // A frame-start beat already uses the threshold it is about to activate.
  assign beat_thr = Frame_Start ? pending_thr_reg : active_thr_reg;
  assign noisy    = AD > beat_thr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_thr_reg <= DEFAULT_THRESHOLD;
      active_thr_reg  <= DEFAULT_THRESHOLD;
    end else begin
      if (Threshold_Load) begin
        pending_thr_reg <= Threshold;
      end
      if (accept && Frame_Start) begin
        active_thr_reg <= pending_thr_reg;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_reg  <= 1'b0;
      s1_pix_reg    <= '0;
      s1_flag_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pix_reg   <= '0;
      out_flag_reg  <= 1'b0;
    end else begin
      if (In_Ready) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_pix_reg  <= noisy ? MV : CV;
          s1_flag_reg <= noisy;
        end
      end
      if (adv2) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_pix_reg  <= s1_pix_reg;
          out_flag_reg <= s1_flag_reg;
        end
      end
    end
  end

  assign Out_Valid  = out_valid_reg;
  assign Pixel_Out  = out_pix_reg;
  assign Noise_Flag = out_flag_reg;

  frame_noise_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk        (Clk),
    .srst       (Reset),
    .accept     (accept),
    .noisy      (noisy),
    .frame_start(Frame_Start),
    .frame_end  (Frame_End),
    .noise_count(Noise_Count),
    .count_valid(Count_Valid),
    .sync_error (Sync_Error)
  );

endmodule

// File: tb/tb_switch_decision_stage.sv
// Bench for switch_decision_stage: directed vector table, backpressure, framing
// and reset sequences, saturation, and a randomized run against a frame-level model.
module tb_switch_decision_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [7:0]  CV = '0;
  logic [7:0]  MV = '0;
  logic [7:0]  AD = '0;
  logic        Frame_Start = 1'b0;
  logic        Frame_End = 1'b0;
  logic [7:0]  Threshold = '0;
  logic        Threshold_Load = 1'b0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [7:0]  Pixel_Out;
  logic        Noise_Flag;
  logic [15:0] Noise_Count;
  logic        Count_Valid;
  logic        Sync_Error;

  switch_decision_stage #(
    .DEFAULT_THRESHOLD(8'd40),
    .CNT_W            (16)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .In_Valid      (In_Valid),
    .In_Ready      (In_Ready),
    .CV            (CV),
    .MV            (MV),
    .AD            (AD),
    .Frame_Start   (Frame_Start),
    .Frame_End     (Frame_End),
    .Threshold     (Threshold),
    .Threshold_Load(Threshold_Load),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready),
    .Pixel_Out     (Pixel_Out),
    .Noise_Flag    (Noise_Flag),
    .Noise_Count   (Noise_Count),
    .Count_Valid   (Count_Valid),
    .Sync_Error    (Sync_Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] cv;
    logic [7:0] mv;
    logic [7:0] ad;
    logic       fs;
    logic       fe;
  } beat_t;

  typedef struct {
    logic [7:0]  cv;
    logic [7:0]  mv;
    logic [7:0]  ad;
    logic        fs;
    logic        fe;
    logic        tl;
    logic [7:0]  thr;
    logic [7:0]  e_pix;
    logic        e_flag;
    logic        e_cv;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] pix;
    logic       flag;
    int         cyc;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   abort = 0;
  bit   lat_on = 0;
  bit   or_random = 0;
  bit   or_force = 1;

  // Reference model state: thresholds, frame bookkeeping, expected output stream.
  exp_t q[$];
  int   m_act = 40;
  int   m_pend = 40;
  bit   m_in_frame = 0;
  int   m_fcnt = 0;
  bit   m_sync = 0;
  bit   exp_cv = 0;
  int   exp_cnt = 0;
  bit   hold_prev = 0;
  logic [7:0] hold_pix;
  logic hold_flag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge Clk) begin
    #2;
    Out_Ready = or_random ? ($urandom_range(0, 3) != 0) : or_force;
  end

  always @(negedge Clk) begin
    cyc++;
    if (Reset) begin
      q.delete();
      m_act = 40;
      m_pend = 40;
      m_in_frame = 0;
      m_fcnt = 0;
      m_sync = 0;
      exp_cv = 0;
      hold_prev = 0;
    end else begin
      if (exp_cv || Count_Valid) begin
        chk("count_valid", Count_Valid, exp_cv);
        if (exp_cv) chk("noise_count", Noise_Count, exp_cnt);
      end
      exp_cv = 0;
      if (hold_prev) begin
        chk("hold_valid", Out_Valid, 1);
        chk("hold_pixel", Pixel_Out, hold_pix);
        chk("hold_flag", Noise_Flag, hold_flag);
      end
      hold_prev = Out_Valid && !Out_Ready;
      hold_pix = Pixel_Out;
      hold_flag = Noise_Flag;
      if (Out_Valid && Out_Ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pixel_out", Pixel_Out, e.pix);
          chk("noise_flag", Noise_Flag, e.flag);
          if (lat_on) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (In_Valid && In_Ready) begin
        int  thr;
        bit  nz;
        acc_cnt++;
        thr = Frame_Start ? m_pend : m_act;
        nz = (int'(AD) > thr);
        q.push_back('{nz ? MV : CV, nz, cyc});
        if (Frame_Start) begin
          if (m_in_frame) m_sync = 1;
          m_act = m_pend;
          m_in_frame = 1;
          m_fcnt = 0;
        end else if (!m_in_frame) begin
          m_sync = 1;
        end
        if (m_in_frame) begin
          m_fcnt += int'(nz);
          if (Frame_End) begin
            exp_cv = 1;
            exp_cnt = (m_fcnt > 65535) ? 65535 : m_fcnt;
            m_in_frame = 0;
          end
        end
      end
      if (Threshold_Load) m_pend = Threshold;
    end
  end

  task automatic send(input beat_t b, input logic tl, input logic [7:0] thr);
    bit got;
    got = 0;
    if (abort) return;
    CV = b.cv;
    MV = b.mv;
    AD = b.ad;
    Frame_Start = b.fs;
    Frame_End = b.fe;
    Threshold_Load = tl;
    Threshold = thr;
    In_Valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge Clk);
      if (In_Ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: In_Ready stuck at %b, required 1", In_Ready);
      abort = 1;
      In_Valid = 1'b0;
      Threshold_Load = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    Threshold_Load = 1'b0;
    Frame_Start = 1'b0;
    Frame_End = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() != 0; k++) idle(1);
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic beat_t rand_beat(input logic fs, input logic fe);
    beat_t b;
    b.cv = 8'($urandom);
    b.mv = 8'($urandom);
    b.ad = (b.mv > b.cv) ? b.mv - b.cv : b.cv - b.mv;
    if ($urandom_range(0, 9) == 0) b.ad = 8'($urandom);
    b.fs = fs;
    b.fe = fe;
    return b;
  endfunction

  vec_t  vt[12];
  beat_t bp[6];

  initial begin
    beat_t b;
    int    acc0;
    logic [15:0] prev_cnt;
    bit    open;

    vt[0]  = '{8'd100, 8'd20,  8'd80,  1'b1, 1'b0, 1'b0, 8'd0,   8'd20,  1'b1, 1'b0, 16'd0};
    vt[1]  = '{8'd50,  8'd90,  8'd40,  1'b0, 1'b0, 1'b0, 8'd0,   8'd50,  1'b0, 1'b0, 16'd0};
    vt[2]  = '{8'd10,  8'd11,  8'd1,   1'b0, 1'b1, 1'b0, 8'd0,   8'd10,  1'b0, 1'b1, 16'd1};
    vt[3]  = '{8'd30,  8'd33,  8'd3,   1'b1, 1'b0, 1'b0, 8'd0,   8'd30,  1'b0, 1'b0, 16'd0};
    vt[4]  = '{8'd60,  8'd70,  8'd10,  1'b0, 1'b0, 1'b1, 8'd0,   8'd60,  1'b0, 1'b0, 16'd0};
    vt[5]  = '{8'd5,   8'd200, 8'd40,  1'b0, 1'b1, 1'b0, 8'd0,   8'd5,   1'b0, 1'b1, 16'd0};
    vt[6]  = '{8'd7,   8'd8,   8'd1,   1'b1, 1'b0, 1'b0, 8'd0,   8'd8,   1'b1, 1'b0, 16'd0};
    vt[7]  = '{8'd9,   8'd9,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   8'd9,   1'b0, 1'b0, 16'd0};
    vt[8]  = '{8'd255, 8'd0,   8'd255, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 16'd2};
    vt[9]  = '{8'd1,   8'd2,   8'd1,   1'b1, 1'b1, 1'b1, 8'd255, 8'd2,   1'b1, 1'b1, 16'd1};
    vt[10] = '{8'd3,   8'd250, 8'd255, 1'b1, 1'b1, 1'b0, 8'd0,   8'd3,   1'b0, 1'b1, 16'd0};
    vt[11] = '{8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 8'd40,  8'd0,   1'b0, 1'b1, 16'd0};

    // Reset state
    idle(3);
    Reset = 1'b0;
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_pixel_out", Pixel_Out, 0);
    chk("rst_noise_flag", Noise_Flag, 0);
    chk("rst_noise_count", Noise_Count, 0);
    chk("rst_count_valid", Count_Valid, 0);
    chk("rst_sync_error", Sync_Error, 0);

    // Directed vector table, one beat at a time so latency is exact
    lat_on = 1;
    for (int i = 0; i < 12; i++) begin
      b = '{vt[i].cv, vt[i].mv, vt[i].ad, vt[i].fs, vt[i].fe};
      send(b, vt[i].tl, vt[i].thr);
      chk("vec_count_valid", Count_Valid, vt[i].e_cv);
      if (vt[i].e_cv) chk("vec_noise_count", Noise_Count, vt[i].e_cnt);
      idle(1);
      chk("vec_out_valid", Out_Valid, 1);
      chk("vec_pixel", Pixel_Out, vt[i].e_pix);
      chk("vec_flag", Noise_Flag, vt[i].e_flag);
      $display("[TB] vec %0d cv=%0d mv=%0d ad=%0d fs=%0b fe=%0b -> pix=%0d flag=%0b cnt_valid=%0b cnt=%0d",
               i, vt[i].cv, vt[i].mv, vt[i].ad, vt[i].fs, vt[i].fe, Pixel_Out, Noise_Flag,
               vt[i].e_cv, Noise_Count);
    end
    drain();
    lat_on = 0;
    chk("vec_sync_error", Sync_Error, 0);

    // Backpressure: Out_Ready low for 5 cycles while streaming
    for (int i = 0; i < 6; i++) bp[i] = rand_beat(i == 0, i == 5);
    or_force = 0;
    idle(1);
    acc0 = acc_cnt;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 5; c++) begin
        CV = bp[k].cv; MV = bp[k].mv; AD = bp[k].ad;
        Frame_Start = bp[k].fs; Frame_End = bp[k].fe;
        In_Valid = 1'b1;
        @(negedge Clk);
        if (In_Ready === 1'b1) k++;
        @(posedge Clk);
        #1;
      end
      @(negedge Clk);
      chk("bp_in_ready", In_Ready, 0);
      chk("bp_accepted", acc_cnt - acc0, 2);
      @(posedge Clk);
      #1;
      In_Valid = 1'b0;
      Frame_Start = 1'b0;
      or_force = 1;
      for (int i = k; i < 6; i++) send(bp[i], 1'b0, 8'd0);
    end
    drain();
    chk("bp_sync_error", Sync_Error, 0);

    // Framing errors: stray beat in IDLE, then an aborted frame
    do_reset();
    send(rand_beat(1'b0, 1'b0), 1'b0, 8'd0);
    idle(1);
    chk("idle_beat_sync", Sync_Error, 1);
    send(rand_beat(1'b1, 1'b0), 1'b0, 8'd0);
    send('{8'd1, 8'd200, 8'd199, 1'b0, 1'b0}, 1'b0, 8'd0);
    send(rand_beat(1'b1, 1'b0), 1'b0, 8'd0);
    send('{8'd9, 8'd100, 8'd91, 1'b0, 1'b0}, 1'b0, 8'd0);
    send('{8'd9, 8'd10, 8'd1, 1'b0, 1'b1}, 1'b0, 8'd0);
    drain();
    chk("abort_sync", Sync_Error, 1);
    chk("abort_sync_model", Sync_Error, m_sync);

    // Reset with a full pipeline in the middle of a frame
    do_reset();
    send('{8'd0, 8'd90, 8'd90, 1'b1, 1'b0}, 1'b0, 8'd0);
    send('{8'd0, 8'd90, 8'd90, 1'b0, 1'b0}, 1'b0, 8'd0);
    send('{8'd0, 8'd90, 8'd90, 1'b0, 1'b1}, 1'b0, 8'd0);
    drain();
    prev_cnt = Noise_Count;
    chk("pre_reset_count", Noise_Count, 3);
    or_force = 0;
    idle(1);
    send(rand_beat(1'b1, 1'b0), 1'b0, 8'd0);
    send(rand_beat(1'b0, 1'b0), 1'b0, 8'd0);
    chk("full_out_valid", Out_Valid, 1);
    chk("midframe_count_kept", Noise_Count, prev_cnt);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    or_force = 1;
    chk("rst_mid_out_valid", Out_Valid, 0);
    chk("rst_mid_noise_count", Noise_Count, 0);
    chk("rst_mid_sync", Sync_Error, 0);
    send(rand_beat(1'b0, 1'b1), 1'b0, 8'd0);
    drain();
    chk("rst_mid_fsm_idle", Sync_Error, 1);

    // Randomized traffic with random backpressure and threshold loads
    do_reset();
    or_random = 1;
    open = 0;
    for (int n = 0; n < 2500 && !abort; n++) begin
      logic fs, fe, tl;
      if ($urandom_range(0, 3) == 0) idle(1);
      fs = open ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 19) != 0);
      if (fs) open = 1;
      fe = ($urandom_range(0, 24) == 0);
      if (fe) open = 0;
      tl = ($urandom_range(0, 29) == 0);
      send(rand_beat(fs, fe), tl, 8'($urandom_range(0, 100)));
    end
    or_random = 0;
    or_force = 1;
    idle(2);
    drain();
    chk("rand_sync_model", Sync_Error, m_sync);

    // Saturation: one long frame, every pixel noisy
    for (int i = 0; i < 65600 && !abort; i++) begin
      send('{8'd3, 8'd4, 8'd255, i == 0, i == 65599}, 1'b0, 8'd0);
    end
    chk("sat_count_valid", Count_Valid, 1);
    chk("sat_noise_count", Noise_Count, 16'hFFFF);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
